// File: rtl/uc_seq_pkg.sv
// rtl/uc_seq_pkg.sv - opcode, pc_sel and FSM state definitions for uc_seq_ctrl
package uc_seq_pkg;

  localparam logic [5:0] OP_RET  = 6'b111000;
  localparam logic [5:0] OP_CALL = 6'b101000;
  localparam logic [5:0] OP_REL  = 6'b011000;
  localparam logic [5:0] OP_JNZ  = 6'b011111;
  localparam logic [5:0] OP_JZ   = 6'b001111;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_ABS  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;
  localparam logic [1:0] PC_RET  = 2'b11;

  typedef enum logic {
    ST_EXEC = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/uc_ret_stack.sv
// rtl/uc_ret_stack.sv - register-array return-address stack, top read combinationally
module uc_ret_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic [DW-1:0]   depth,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [DW-1:0]   sp_q, sp_d;
  logic [AW-1:0]   top_idx;
  logic            do_push, do_pop;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == DW'(STACK_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top_idx = AW'(sp_q - DW'(1));
  assign top     = empty ? '0 : stack_q[top_idx];
  assign depth   = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + DW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset: anything above sp is never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[sp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uc_seq_ctrl.sv
// rtl/uc_seq_ctrl.sv - CPU control unit with return stack and output handshake; option UC_PRINT_BCAST_EN
module uc_seq_ctrl
  import uc_seq_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8,
  parameter int NUM_OUT     = 4,
  localparam int ID_W       = $clog2(NUM_OUT),
  localparam int SD_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               z,
  input  logic [ID_W-1:0]    id_out,
  input  logic [PC_W-1:0]    pc_plus1,
  input  logic               io_ack,
  output logic [2:0]         alu_op,
  output logic               we3,
  output logic               s_inm,
  output logic               s_es,
  output logic               sec,
  output logic [1:0]         pc_sel,
  output logic               stall,
  output logic [PC_W-1:0]    ret_addr,
  output logic [NUM_OUT-1:0] rwe,
  output logic               vgae,
  output logic [SD_W-1:0]    stk_depth,
  output logic               stk_ovf,
  output logic               stk_unf
);

  state_t             state_q, state_d;
  logic               sec_q, sec_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               push, pop;
  logic [PC_W-1:0]    stk_top;
  logic [SD_W-1:0]    stk_cnt;
  logic               stk_full, stk_empty;
  logic [NUM_OUT-1:0] rwe_one;

  uc_ret_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_plus1),
    .top(stk_top), .depth(stk_cnt), .full(stk_full), .empty(stk_empty)
  );

  assign alu_op    = opcode[2:0];
  assign rwe_one   = NUM_OUT'(1) << id_out;
  assign ret_addr  = reset ? '0 : stk_top;
  assign stk_depth = reset ? '0 : stk_cnt;
  assign stk_ovf   = ovf_q && !reset;
  assign stk_unf   = unf_q && !reset;

  always_comb begin
    we3 = 1'b0; s_inm = 1'b0; s_es = 1'b0; sec = 1'b0;
    pc_sel = PC_NEXT; stall = 1'b0; rwe = '0; vgae = 1'b0;
    push = 1'b0; pop = 1'b0;
    state_d = state_q; sec_d = sec_q; ovf_d = ovf_q; unf_d = unf_q;
    if (!reset) begin
      if (state_q == ST_WAIT) begin
        sec   = sec_q;
        stall = !io_ack;
        if (io_ack) state_d = ST_EXEC;
      end else if (opcode == OP_RET) begin
        if (!stk_empty) begin
          pc_sel = PC_RET;
          pop    = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end else if (opcode == OP_CALL) begin
        pc_sel = PC_ABS;
        if (!stk_full) push = 1'b1;
        else ovf_d = 1'b1;
      end else if (opcode == OP_REL) begin
        pc_sel = PC_REL;
      end else if (opcode == OP_JNZ) begin
        if (!z) pc_sel = PC_ABS;
      end else if (opcode == OP_JZ) begin
        if (z) pc_sel = PC_ABS;
      end else if (opcode != OP_NOP) begin
        casez (opcode[3:0])
          4'b0???: we3 = 1'b1;
          4'b1010: begin we3 = 1'b1; s_inm = 1'b1; end
          4'b1011: begin we3 = 1'b1; s_es = 1'b1; end
          4'b1001: pc_sel = PC_ABS;
          4'b1101, 4'b1110: begin
            sec     = !opcode[1];
            sec_d   = !opcode[1];
            rwe     = rwe_one;
            stall   = 1'b1;
            state_d = ST_WAIT;
          end
`ifdef UC_PRINT_BCAST_EN
          4'b1100: begin sec = 1'b1; vgae = 1'b1; rwe = '1; end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EXEC;
      sec_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_uc_seq_ctrl.sv
// tb/tb_uc_seq_ctrl.sv - directed vector bench for uc_seq_ctrl
module tb_uc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic [1:0] id_out;
  logic [9:0] pc_plus1;
  logic       io_ack;
  logic [2:0] alu_op;
  logic       we3, s_inm, s_es, sec, stall, vgae, stk_ovf, stk_unf;
  logic [1:0] pc_sel;
  logic [9:0] ret_addr;
  logic [3:0] rwe;
  logic [3:0] stk_depth;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  uc_seq_ctrl #(.PC_W(10), .STACK_DEPTH(8), .NUM_OUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .id_out(id_out),
    .pc_plus1(pc_plus1), .io_ack(io_ack), .alu_op(alu_op), .we3(we3),
    .s_inm(s_inm), .s_es(s_es), .sec(sec), .pc_sel(pc_sel), .stall(stall),
    .ret_addr(ret_addr), .rwe(rwe), .vgae(vgae), .stk_depth(stk_depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       we3;
    logic       s_inm;
    logic       s_es;
    logic [1:0] pc;
    logic [3:0] rwe;
    logic       vgae;
    logic       sec;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move just past the next rising edge so new inputs settle well before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{6'b000011, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{6'b000111, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{6'b110100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{6'b011000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{6'b011111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{6'b001111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{6'b111111, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{6'b001010, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{6'b111011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{6'b011001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0};
    vecs[12] = '{6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
`ifdef UC_PRINT_BCAST_EN
    vecs[13] = '{6'b001100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b1, 1'b1};
`else
    vecs[13] = '{6'b001100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0};
`endif

    reset = 1'b1; opcode = 6'b000011; z = 1'b0; id_out = 2'd0;
    pc_plus1 = '0; io_ack = 1'b0;
    step();
    #1;
    check("rst_we3", {31'd0, we3}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd3);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_depth", {28'd0, stk_depth}, 32'd0);
    check("post_rst_ovf", {31'd0, stk_ovf}, 32'd0);
    check("post_rst_unf", {31'd0, stk_unf}, 32'd0);
    check("post_rst_ret", {22'd0, ret_addr}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      step();
      opcode = vecs[i].op; z = vecs[i].z;
      #1;
      check($sformatf("v%0d_we3", i), {31'd0, we3}, {31'd0, vecs[i].we3});
      check($sformatf("v%0d_s_inm", i), {31'd0, s_inm}, {31'd0, vecs[i].s_inm});
      check($sformatf("v%0d_s_es", i), {31'd0, s_es}, {31'd0, vecs[i].s_es});
      check($sformatf("v%0d_pc_sel", i), {30'd0, pc_sel}, {30'd0, vecs[i].pc});
      check($sformatf("v%0d_rwe", i), {28'd0, rwe}, {28'd0, vecs[i].rwe});
      check($sformatf("v%0d_vgae", i), {31'd0, vgae}, {31'd0, vecs[i].vgae});
      check($sformatf("v%0d_sec", i), {31'd0, sec}, {31'd0, vecs[i].sec});
      check($sformatf("v%0d_alu", i), {29'd0, alu_op}, {29'd0, vecs[i].op[2:0]});
      check($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
    end

    // Three nested calls, then unwind.
    for (int i = 0; i < 3; i++) begin
      step();
      opcode = 6'b101000; pc_plus1 = 10'((i + 1) * 16);
      #1;
      check($sformatf("call%0d_pc_sel", i), {30'd0, pc_sel}, 32'd1);
    end
    step();
    opcode = 6'b111000;
    #1;
    check("nest_depth3", {28'd0, stk_depth}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      check($sformatf("ret%0d_pc_sel", i), {30'd0, pc_sel}, 32'd3);
      check($sformatf("ret%0d_addr", i), {22'd0, ret_addr}, 32'((3 - i) * 16));
    end
    step();
    opcode = 6'b000000;
    #1;
    check("nest_depth0", {28'd0, stk_depth}, 32'd0);
    check("nest_ovf", {31'd0, stk_ovf}, 32'd0);
    check("nest_unf", {31'd0, stk_unf}, 32'd0);

    // Overflow: nine calls into an eight-entry stack.
    for (int i = 0; i < 9; i++) begin
      step();
      opcode = 6'b101000; pc_plus1 = 10'(32'h100 + i);
      #1;
      check($sformatf("ovcall%0d_pc_sel", i), {30'd0, pc_sel}, 32'd1);
    end
    step();
    opcode = 6'b000000;
    #1;
    check("ovf_flag", {31'd0, stk_ovf}, 32'd1);
    check("ovf_depth", {28'd0, stk_depth}, 32'd8);
    check("ovf_top", {22'd0, ret_addr}, 32'h107);
    for (int i = 0; i < 8; i++) begin
      step();
      opcode = 6'b111000;
    end
    step();
    #1;
    check("unf_pc_sel", {30'd0, pc_sel}, 32'd0);
    check("unf_ret_addr", {22'd0, ret_addr}, 32'd0);
    step();
    opcode = 6'b000000;
    #1;
    check("unf_flag", {31'd0, stk_unf}, 32'd1);
    check("unf_depth", {28'd0, stk_depth}, 32'd0);
    check("ovf_still", {31'd0, stk_ovf}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("sticky_clr_ovf", {31'd0, stk_ovf}, 32'd0);
    check("sticky_clr_unf", {31'd0, stk_unf}, 32'd0);

    // OUT reg, port 2, ack three WAIT cycles later.
    stall_cnt = 0;
    step();
    opcode = 6'b001101; id_out = 2'd2; io_ack = 1'b0;
    #1;
    check("out_rwe", {28'd0, rwe}, 32'b0100);
    check("out_sec", {31'd0, sec}, 32'd1);
    if (stall) stall_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      opcode = 6'b000011;
      #1;
      check($sformatf("wait%0d_rwe", i), {28'd0, rwe}, 32'd0);
      check($sformatf("wait%0d_we3", i), {31'd0, we3}, 32'd0);
      check($sformatf("wait%0d_sec", i), {31'd0, sec}, 32'd1);
      if (stall) stall_cnt++;
    end
    step();
    io_ack = 1'b1;
    #1;
    check("ack_stall", {31'd0, stall}, 32'd0);
    check("ack_pc_sel", {30'd0, pc_sel}, 32'd0);
    check("ack_rwe", {28'd0, rwe}, 32'd0);
    check("stall_cycles", 32'(stall_cnt), 32'd4);
    step();
    #1;
    check("exec_ack_ignored_stall", {31'd0, stall}, 32'd0);
    check("exec_we3", {31'd0, we3}, 32'd1);
    io_ack = 1'b0;

    // OUT mem, port 0, minimum latency.
    step();
    opcode = 6'b111110; id_out = 2'd0;
    #1;
    check("outm_rwe", {28'd0, rwe}, 32'b0001);
    check("outm_sec", {31'd0, sec}, 32'd0);
    step();
    io_ack = 1'b1;
    #1;
    check("outm_ack_stall", {31'd0, stall}, 32'd0);
    check("outm_ack_sec", {31'd0, sec}, 32'd0);
    step();
    io_ack = 1'b0; opcode = 6'b000011;
    #1;
    check("outm_exec_we3", {31'd0, we3}, 32'd1);

    // Reset while waiting for an acknowledge.
    step();
    opcode = 6'b101000; pc_plus1 = 10'h055;
    step();
    opcode = 6'b001101; id_out = 2'd3;
    #1;
    check("rw_out_rwe", {28'd0, rwe}, 32'b1000);
    step();
    #1;
    check("rw_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("rw_rst_rwe", {28'd0, rwe}, 32'd0);
    check("rw_rst_stall", {31'd0, stall}, 32'd0);
    step();
    reset = 1'b0; opcode = 6'b000011;
    #1;
    check("rw_after_stall", {31'd0, stall}, 32'd0);
    check("rw_after_rwe", {28'd0, rwe}, 32'd0);
    check("rw_after_we3", {31'd0, we3}, 32'd1);
    check("rw_after_depth", {28'd0, stk_depth}, 32'd0);
    step();
    #1;
    check("rw_later_rwe", {28'd0, rwe}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_seq_ctrl.md
Name: uc_seq_ctrl

Overview:
- Next-generation control unit for the single-cycle CPU: decodes the 6-bit opcode into datapath controls and PC-source selection.
- Adds a hardware return-address stack of configurable depth for nested subroutines, replacing the single return register.
- Adds NUM_OUT one-hot output-port write enables and an output handshake that stalls the PC until the port acknowledges.
- Sits between instruction memory and the PC mux, register file and I/O ports.

Parameters:
- PC_W, 10, program counter / return address width
- STACK_DEPTH, 8, return-stack entries (>=2)
- NUM_OUT, 4, number of output ports (>=2); ID_W = $clog2(NUM_OUT)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  6  instruction opcode field
- z  in  1  ALU zero flag
- id_out  in  ID_W  output port index from instruction
- pc_plus1  in  PC_W  address of next sequential instruction (value pushed on call)
- io_ack  in  1  selected output port has accepted data
- alu_op  out  3  opcode[2:0], always
- we3  out  1  register-file write enable
- s_inm  out  1  writeback selects immediate
- s_es  out  1  writeback selects input port
- sec  out  1  output data source: 1 register, 0 memory
- pc_sel  out  2  00 pc+1, 01 absolute target, 10 relative, 11 ret_addr
- stall  out  1  hold PC (pc_sel ignored while high)
- ret_addr  out  PC_W  top-of-stack; 0 when empty
- rwe  out  NUM_OUT  output-port write strobes, one-hot or zero
- vgae  out  1  VGA draw enable
- stk_depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy
- stk_ovf  out  1  sticky: call with full stack
- stk_unf  out  1  sticky: return with empty stack

Behaviour:
- Default for every output: 0; pc_sel=00; alu_op follows opcode.
- While reset is high: all of the above, regardless of opcode. On the next clock: state=EXEC, sp=0, stk_ovf=stk_unf=0. Reset during WAIT aborts the transfer with no further rwe.
- Decode in EXEC, priority order (exact matches first, unlike a pure casex on bit 3):
  - 111000 RET: if sp>0, pc_sel=11 and pop at clock edge. If empty: pc_sel=00, set stk_unf, no pop.
  - 101000 CALL: pc_sel=01. If sp<DEPTH, push pc_plus1. If full: set stk_ovf, no push, stack unchanged, jump still taken.
  - 011000 REL: pc_sel=10.
  - 011111 JNZ: pc_sel=01 if z=0, else 00.
  - 001111 JZ: pc_sel=01 if z=1, else 00.
  - 111111 NOP: defaults.
  - xx0xxx ALU: we3=1.
  - xx1010 LI: we3=1, s_inm=1.
  - xx1011 LES: we3=1, s_es=1.
  - xx1001 JMP: pc_sel=01.
  - xx1101 / xx1110 OUT (reg / mem): sec=1 / 0; rwe[id_out]=1 for exactly one cycle; stall=1; next state WAIT.
  - xx1100 PRINT: see optional feature.
  - Any other opcode: NOP.
- FSM states:
  - EXEC: as decoded above.
  - WAIT: stall=1, rwe=0, we3=0, stack frozen, sec held at its OUT value.
  - On a cycle with io_ack=1 in WAIT: stall=0, pc_sel=00, next state EXEC.
  - io_ack in EXEC is ignored. Minimum OUT latency is 2 cycles (strobe, ack).
- Stack storage: register array. ret_addr is combinational from entry sp-1. Push and pop never occur in the same cycle.

Optional Feature:
- UC_PRINT_BCAST_EN defined: xx1100 sets sec=1, vgae=1 and rwe to all ones for one cycle, with no stall and no WAIT.
- Undefined: xx1100 decodes as NOP and vgae is tied 0.

Decomposition:
- Package uc_seq_pkg: opcode localparams (OP_RET, OP_CALL, OP_REL, OP_JNZ, OP_JZ, OP_NOP), pc_sel encoding constants, FSM state enum.
- One sub-module: uc_ret_stack (params PC_W, STACK_DEPTH). Ports: push, pop, din, top, depth, full, empty.

Test Plan:
- Reset, then opcode=000011 -> we3=1, alu_op=011, pc_sel=00, rwe=0, stk_depth=0.
- 3 nested CALLs with pc_plus1=0x010, 0x020, 0x030, then 3 RETs -> ret_addr 0x030, 0x020, 0x010 in order; depth 3->0; no sticky flags.
- STACK_DEPTH+1 CALLs -> last one: pc_sel=01, stk_ovf=1, depth stays 8. RET with empty stack -> pc_sel=00, stk_unf=1.
- OUT xx1101 with id_out=2, io_ack asserted 3 cycles later -> rwe=0100 for 1 cycle, stall high 4 cycles, then pc_sel=00.
- Reset asserted mid-WAIT -> next cycle stall=0, state EXEC, rwe never re-pulses; stack empties.
- Opcode 011111 with z=0 / z=1 -> pc_sel=01 / 00. Opcode 011000 -> pc_sel=10, we3=0 (priority check).
